// File: rtl/arm_instr_serializer.sv
// arm_instr_serializer: accepts a bundle of up to six packed ARM words and streams them,
// slot 0 first, into a program-memory write port with a running word address.
// Tracks the memory fill level, stops for good when the memory is full and raises sticky
// flags for dropped words and illegal bundle sizes.
module arm_instr_serializer #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [191:0]          instructions,
    input  logic [2:0]            quantity,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  bundle_done,
    output logic                  full,
    output logic                  overflow,
    output logic                  bad_quantity
);

    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StEmit, StFull} state_t;

    state_t              state_q;
    logic [31:0]         slots_q [6];
    logic [2:0]          qty_q;
    logic [2:0]          idx_q;
    logic [ADDR_WIDTH:0] count_next;
    logic                last_slot;

    // Addresses never wrap, so the accepted-word count doubles as the write pointer.
    assign count_next = word_count + (ADDR_WIDTH + 1)'(1);
    assign last_slot  = (idx_q == qty_q - 3'd1);

    // Control FSM with registered handshake outputs, data path and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            qty_q        <= 3'd0;
            idx_q        <= 3'd0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_addr     <= '0;
            word_count   <= '0;
            bundle_done  <= 1'b0;
            full         <= 1'b0;
            overflow     <= 1'b0;
            bad_quantity <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                slots_q[k] <= 32'd0;
            end
        end else begin
            bundle_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (write_enable) begin
                        if (quantity == 3'd7) begin
                            bad_quantity <= 1'b1;
                        end else if (quantity != 3'd0) begin
                            for (int k = 0; k < 6; k++) begin
                                slots_q[k] <= instructions[32*k +: 32];
                            end
                            qty_q     <= quantity;
                            idx_q     <= 3'd0;
                            // Slot 0 is presented straight from the input so it is valid
                            // one cycle after acceptance.
                            out_data  <= instructions[31:0];
                            out_addr  <= word_count[ADDR_WIDTH-1:0];
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state_q   <= StEmit;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        word_count <= count_next;
                        idx_q      <= idx_q + 3'd1;
                        if (count_next == DepthW) begin
                            // Memory exhausted: any remaining slots are lost.
                            full      <= 1'b1;
                            out_valid <= 1'b0;
                            state_q   <= StFull;
                            if (last_slot) begin
                                bundle_done <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (last_slot) begin
                            bundle_done <= 1'b1;
                            out_valid   <= 1'b0;
                            in_ready    <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            out_data <= slots_q[idx_q + 3'd1];
                            out_addr <= out_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                StFull: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_instr_serializer.sv
// Self-checking bench for arm_instr_serializer: directed scenarios plus randomized bundles
// checked cycle by cycle against a queue-based model of the expected word stream.
module tb_arm_instr_serializer;

    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_enable = 1'b0;
    logic [191:0]  instructions = '0;
    logic [2:0]    quantity = 3'd0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;
    logic [AW:0]   word_count;
    logic          bundle_done;
    logic          full;
    logic          overflow;
    logic          bad_quantity;

    arm_instr_serializer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .instructions (instructions),
        .quantity     (quantity),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .word_count   (word_count),
        .bundle_done  (bundle_done),
        .full         (full),
        .overflow     (overflow),
        .bad_quantity (bad_quantity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        bit            last;
    } word_t;

    // Reference model: words still owed downstream, words already accepted, sticky flags.
    word_t exp_q[$];
    int    m_used;
    int    m_count;
    bit    m_bad;
    bit    m_drop;
    bit    exp_done;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_used   = 0;
        m_count  = 0;
        m_bad    = 0;
        m_drop   = 0;
        exp_done = 0;
    endtask

    task automatic accept_bundle(input logic [191:0] ins, input logic [2:0] qty);
        word_t w;
        if (qty == 3'd7) begin
            m_bad = 1;
        end else begin
            for (int k = 0; k < int'(qty); k++) begin
                if (m_used < DEPTH) begin
                    w.data = ins[32*k +: 32];
                    w.addr = AW'(m_used);
                    w.last = (k == int'(qty) - 1);
                    exp_q.push_back(w);
                    m_used++;
                end else begin
                    m_drop = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input bit we, input logic [191:0] ins, input logic [2:0] qty,
                        input bit rdy);
        bit exp_in_ready;
        @(negedge clk);
        write_enable = we;
        instructions = ins;
        quantity     = qty;
        out_ready    = rdy;
        #1;
        exp_in_ready = (exp_q.size() == 0) && (m_count != DEPTH);
        check_eq("in_ready", in_ready, exp_in_ready);
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        check_eq("bundle_done", bundle_done, exp_done);
        check_eq("word_count", word_count, m_count);
        check_eq("full", full, m_count == DEPTH);
        check_eq("overflow", overflow, m_drop && (m_count == DEPTH));
        check_eq("bad_quantity", bad_quantity, m_bad);
        exp_done = 0;
        if (exp_q.size() != 0) begin
            check_eq("out_data", out_data, exp_q[0].data);
            check_eq("out_addr", out_addr, exp_q[0].addr);
            if (rdy) begin
                exp_done = exp_q[0].last;
                void'(exp_q.pop_front());
                m_count++;
            end
        end
        if (we && exp_in_ready) begin
            accept_bundle(ins, qty);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        write_enable = 1'b0;
        out_ready    = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_addr", out_addr, 0);
        check_eq("rst_word_count", word_count, 0);
        check_eq("rst_flags", {bundle_done, full, overflow, bad_quantity}, 0);
    endtask

    task automatic send(input logic [191:0] ins, input logic [2:0] qty);
        step(1'b1, ins, qty, 1'b1);
    endtask

    task automatic drain(input int pct);
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
            step(1'b0, '0, 3'd0, $urandom_range(99) < pct);
        end
        check_eq("drain_timeout", exp_q.size(), 0);
        step(1'b0, '0, 3'd0, 1'b1);
    endtask

    function automatic logic [191:0] rand_bundle();
        logic [191:0] r;
        for (int k = 0; k < 6; k++) begin
            r[32*k +: 32] = $urandom;
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] b;
        model_reset();
        do_reset();

        // Two-word bundle, downstream always ready.
        b = '0;
        b[63:0] = {32'hE92D0002, 32'hE3A01001};
        send(b, 3'd2);
        drain(100);

        // Same bundle with word 0 stalled for three cycles.
        send(b, 3'd2);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 3'd0, 1'b0);
        step(1'b0, '0, 3'd0, 1'b1);
        step(1'b0, '0, 3'd0, 1'b1);
        drain(100);

        // Empty and illegal bundles, then a single word at address 0.
        do_reset();
        send(rand_bundle(), 3'd0);
        step(1'b0, '0, 3'd0, 1'b1);
        send(rand_bundle(), 3'd7);
        step(1'b0, '0, 3'd0, 1'b1);
        send(rand_bundle(), 3'd1);
        drain(100);

        // Overflow: 6+3+2 words fill 11 of 12, next bundle only fits one word.
        do_reset();
        send(rand_bundle(), 3'd6); drain(70);
        send(rand_bundle(), 3'd3); drain(70);
        send(rand_bundle(), 3'd2); drain(70);
        send(rand_bundle(), 3'd2); drain(70);
        send(rand_bundle(), 3'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 3'd0, 1'b1);

        // Exact fill, no overflow, both bundles complete.
        do_reset();
        send(rand_bundle(), 3'd6); drain(100);
        send(rand_bundle(), 3'd6); drain(100);
        step(1'b0, '0, 3'd0, 1'b1);

        // Reset in the middle of a six-word bundle.
        do_reset();
        send(rand_bundle(), 3'd6);
        step(1'b0, '0, 3'd0, 1'b1);
        do_reset();
        send(rand_bundle(), 3'd1);
        drain(100);

        // Randomized bundles and backpressure.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (m_count == DEPTH) begin
                do_reset();
            end
            send(rand_bundle(), 3'($urandom_range(7)));
            drain(int'($urandom_range(30, 100)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
